mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_responder_array.sv | 43 ++++
 rtl/mem_responder.sv | 157 +++++++++++++++
 tb/tb_mem_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder request/response memory slave.
// State encoding, write-enable polarity and the legal LATENCY window live here.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    localparam logic WEN_WRITE = 1'b0;
    localparam logic WEN_READ  = 1'b1;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 15;

    // Wide enough for LATENCY_MAX - 2, so the countdown can never wrap.
    localparam int unsigned CNT_W = 4;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: synchronous write, registered read port and a
// synchronous clear of every word plus the read register on rst.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic          rd_en_i,
    input  logic          rd_zero_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[AW'(i)] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            // Write acks and rejected accesses report zero data.
            if (rd_en_i) begin
                rdata_q <= mem_q[addr_i];
            end else if (rd_zero_i) begin
                rdata_q <= '0;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with a fixed LATENCY from accept to response.
// Optional out-of-range reporting on rsp_err is built only with MEM_RESPONDER_ERR_EN.
//
// state | meaning
// IDLE  | req_ready high, waiting for req_valid
// WAIT  | request latched, countdown running toward the access
// RESP  | rsp_valid high, holding data until rsp_ready
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
`ifdef MEM_RESPONDER_ERR_EN
    output logic        rsp_err,
`endif
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("mem_responder: LATENCY must lie within 1..15");
    end
    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("mem_responder: DEPTH must be a power of two and at least 2");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wen_q, wen_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             acc_fire;

    logic             acc_wen;
    logic [15:0]      acc_addr;
    logic [15:0]      acc_wdata;
    logic             acc_oor;
    logic             wr_en, rd_en, rd_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wen_q   <= WEN_READ;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        acc_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        acc_fire = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    acc_fire = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY = 1 the access fires on the accept edge, before the latch is loaded.
    assign acc_wen   = (state_q == IDLE) ? req_wen   : wen_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

`ifdef MEM_RESPONDER_ERR_EN
    logic err_q;

    assign acc_oor = (32'(acc_addr) >= DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (acc_fire) begin
            err_q <= acc_oor;
        end
    end

    assign rsp_err = err_q;
`else
    // Upper address bits alias onto the array when range checking is not built.
    logic unused_addr_hi;

    assign acc_oor        = 1'b0;
    assign unused_addr_hi = ^acc_addr;
`endif

    assign wr_en   = acc_fire && (acc_wen == WEN_WRITE) && !acc_oor;
    assign rd_en   = acc_fire && (acc_wen == WEN_READ) && !acc_oor;
    assign rd_zero = acc_fire && ((acc_wen == WEN_WRITE) || acc_oor);

    mem_responder_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .rd_en_i   (rd_en),
        .rd_zero_i (rd_zero),
        .addr_i    (acc_addr[AW-1:0]),
        .wdata_i   (acc_wdata),
        .rdata_o   (rsp_rdata)
    );

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios, a randomized phase
// checked every cycle against a timing/storage model, and a LATENCY=1 instance.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
`ifdef MEM_RESPONDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_wen = 1'b1, rsp_ready = 1'b1;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, busy;
    logic [15:0] rsp_rdata;

    logic        req_valid2 = 1'b0, req_wen2 = 1'b1, rsp_ready2 = 1'b1;
    logic [15:0] req_addr2 = '0, req_wdata2 = '0;
    logic        req_ready2, rsp_valid2, busy2;
    logic [15:0] rsp_rdata2;
`ifdef MEM_RESPONDER_ERR_EN
    logic        rsp_err, rsp_err2;
`endif

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef MEM_RESPONDER_ERR_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_wen(req_wen2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
`ifdef MEM_RESPONDER_ERR_EN
        .rsp_err(rsp_err2),
`endif
        .busy(busy2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out t=%0t", nm, $time);
    endtask

    // Reference model: one outstanding request; response valid once LATENCY
    // cycles have elapsed since the accept cycle; storage is a plain array.
    logic [15:0] mmem [DEPTH];
    bit          m_busy = 1'b0;
    int          m_age = 0;
    logic [15:0] m_rdata = '0;
    bit          m_err = 1'b0;
    bit          p_wen;
    logic [15:0] p_addr, p_wdata;

    task automatic model_access();
        bit oor;
        oor   = ERR_EN && (int'(p_addr) >= DEPTH);
        m_err = oor;
        if (oor) m_rdata = '0;
        else if (p_wen == 1'b0) begin
            mmem[int'(p_addr) % DEPTH] = p_wdata;
            m_rdata = '0;
        end else m_rdata = mmem[int'(p_addr) % DEPTH];
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_age   = 0;
            m_rdata = '0;
            m_err   = 1'b0;
            for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        end else if (!m_busy) begin
            if (req_valid) begin
                p_wen   = req_wen;
                p_addr  = req_addr;
                p_wdata = req_wdata;
                m_busy  = 1'b1;
                m_age   = 1;
                if (m_age == LAT) model_access();
            end
        end else if (m_age >= LAT) begin
            if (rsp_ready) m_busy = 1'b0;
        end else begin
            m_age++;
            if (m_age == LAT) model_access();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_ready", req_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, m_busy && m_age >= LAT);
            if (m_busy && m_age >= LAT) begin
                chk("rsp_rdata", rsp_rdata, m_rdata);
`ifdef MEM_RESPONDER_ERR_EN
                chk("rsp_err", rsp_err, m_err);
`endif
            end
        end
    end

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout("wait_rsp");
    endtask

    // Called at a negedge; returns at the negedge of the first response cycle.
    task automatic issue(input logic wen, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output int busy_n,
                         output logic [15:0] rd, output logic er);
        int n;
        req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) timeout("accept");
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!rsp_valid && lat < 50) begin
            if (busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) timeout("response");
        if (busy) busy_n++;
        rd = rsp_rdata;
`ifdef MEM_RESPONDER_ERR_EN
        er = rsp_err;
`else
        er = 1'b0;
`endif
    endtask

    function automatic logic [15:0] rnd_addr();
        int unsigned s;
        s = $urandom_range(0, 7);
        if (s == 0) return 16'($urandom);
        if (s == 1) return 16'h0100 | 16'($urandom_range(0, 15));
        return 16'($urandom_range(0, 15));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int lat, bn, n;
        logic [15:0] rd;
        logic er;
        bit last_ready, last_rst;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rdata", rsp_rdata, 16'h0000);

        issue(1'b0, 16'h0005, 16'hBEEF, lat, bn, rd, er);
        chk("wr_latency", lat, LAT);
        chk("wr_busy_cycles", bn, LAT);
        chk("wr_rdata", rd, 16'h0000);
        chk("ready_in_resp", req_ready, 1'b0);
        @(negedge clk);
        chk("ready_after_hs", req_ready, 1'b1);

        issue(1'b1, 16'h0005, 16'h0000, lat, bn, rd, er);
        chk("raw_rdata", rd, 16'hBEEF);
        chk("rd_latency", lat, LAT);

        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b1, 16'h0005, 16'h0000, lat, bn, rd, er);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 16'h0007; req_wdata = 16'h7777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_rdata", rsp_rdata, 16'hBEEF);
            chk("hold_no_accept", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("released_valid", rsp_valid, 1'b0);
        chk("released_ready", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(n);
        @(negedge clk);

        req_valid = 1'b1; req_wen = 1'b0; req_addr = 16'h0010; req_wdata = 16'h1234;
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rdata", rsp_rdata, 16'h0000);
        rst = 1'b0;
        issue(1'b1, 16'h0010, 16'h0000, lat, bn, rd, er);
        chk("discarded_write", rd, 16'h0000);

        issue(1'b0, 16'h0105, 16'hAAAA, lat, bn, rd, er);
        chk("oor_wr_latency", lat, LAT);
`ifdef MEM_RESPONDER_ERR_EN
        chk("oor_wr_err", er, 1'b1);
`endif
        issue(1'b1, 16'h0005, 16'h0000, lat, bn, rd, er);
`ifdef MEM_RESPONDER_ERR_EN
        chk("oor_rd_rdata", rd, 16'h0000);
        chk("oor_rd_err", er, 1'b0);
`else
        chk("alias_rd_rdata", rd, 16'hAAAA);
`endif

        last_ready = 1'b0;
        last_rst = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (req_valid && last_ready && !last_rst) req_valid = 1'b0;
            last_rst = rst;
            rst = 1'b0;
            if (!req_valid && $urandom_range(0, 2) == 0) begin
                req_valid = 1'b1;
                req_wen   = 1'($urandom_range(0, 1));
                req_addr  = rnd_addr();
                req_wdata = 16'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            last_ready = req_ready;
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout("drain");

        chk("l1_idle_ready", req_ready2, 1'b1);
        req_valid2 = 1'b1; req_wen2 = 1'b0; req_addr2 = 16'h0003; req_wdata2 = 16'h5A5A;
        @(negedge clk);
        chk("l1_wr_valid", rsp_valid2, 1'b1);
        chk("l1_wr_rdata", rsp_rdata2, 16'h0000);
        chk("l1_wr_ready", req_ready2, 1'b0);
        req_wen2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("l1_ready", req_ready2, (i % 2) == 0);
            chk("l1_valid", rsp_valid2, (i % 2) == 1);
            if (i % 2 == 1) chk("l1_rdata", rsp_rdata2, 16'h5A5A);
        end
        req_valid2 = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
